// File: rtl/turbo_pkg.sv
// Shared turbo-encoder constants: block sizes, QPP coefficients, the
// precomputed recursion seeds and the interleaver FSM state encoding.
package turbo_pkg;

  localparam int KMAX     = 6144;
  localparam int AW       = 13;

  localparam int K_SMALL  = 1056;
  localparam int K_LARGE  = 6144;

  localparam int F1_SMALL = 17;
  localparam int F2_SMALL = 66;
  localparam int F1_LARGE = 263;
  localparam int F2_LARGE = 480;

  // g(0) = (f1 + f2) mod K : 83 / 743
  localparam int G0_SMALL = (F1_SMALL + F2_SMALL) % K_SMALL;
  localparam int G0_LARGE = (F1_LARGE + F2_LARGE) % K_LARGE;
  // per-step increment of g : 2*f2 mod K = 132 / 960
  localparam int D2_SMALL = (2 * F2_SMALL) % K_SMALL;
  localparam int D2_LARGE = (2 * F2_LARGE) % K_LARGE;

  localparam int TAIL_LEN = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_READ = 2'd2,
    ST_TAIL = 2'd3
  } state_t;

  function automatic logic [AW-1:0] kval_of(input logic ksel);
    return ksel ? AW'(K_LARGE) : AW'(K_SMALL);
  endfunction

  function automatic logic [AW-1:0] g0_of(input logic ksel);
    return ksel ? AW'(G0_LARGE) : AW'(G0_SMALL);
  endfunction

  function automatic logic [AW-1:0] d2_of(input logic ksel);
    return ksel ? AW'(D2_LARGE) : AW'(D2_SMALL);
  endfunction

  // (a + b) mod m for a, b < m: a single compare-and-subtract.
  function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                            input logic [AW-1:0] b,
                                            input logic [AW-1:0] m);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[AW-1:0];
  endfunction

endpackage

// File: rtl/qpp_addr_gen.sv
// QPP address generator: pi(i) = (f1*i + f2*i^2) mod K produced one index
// per step through the pi/g recursion, so no multipliers are needed.
module qpp_addr_gen
  import turbo_pkg::*;
(
  input  logic          clk,
  input  logic          aclr,
  input  logic          ksel,
  input  logic          load,
  input  logic          step,
  output logic [AW-1:0] pi
);

  logic [AW-1:0] g_q;
  logic [AW-1:0] kval;

  assign kval = kval_of(ksel);

  // load seeds pi(0)=0, g(0); each step advances pi by g and g by 2*f2
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      pi  <= '0;
      g_q <= '0;
    end else if (load) begin
      pi  <= '0;
      g_q <= g0_of(ksel);
    end else if (step) begin
      pi  <= mod_add(pi, g_q, kval);
      g_q <= mod_add(g_q, d2_of(ksel), kval);
    end
  end

endmodule

// File: rtl/qpp_interleaver.sv
// Turbo-encoder front end: buffers one K-bit block in natural order, then
// streams it out as natural (ck) and QPP-interleaved (ck_int) bits, followed
// by a trellis-termination gap.
//
// Input handshake: din is taken on a rising edge where din_valid && in_ready.
// in_ready depends only on the FSM state (high in IDLE and LOAD), never on
// din_valid, so a source may hold din_valid high while in_ready is low and
// those bits are simply dropped.
module qpp_interleaver
  import turbo_pkg::*;
(
  input  logic   clk,
  input  logic   aclr,
  input  logic   K,
  input  logic   din,
  input  logic   din_valid,
  output logic   in_ready,
  output logic   data_ready,
  output logic   ck,
  output logic   ck_int,
  output logic   out_valid,
  output logic   busy,
  output state_t dbg_state
);

  state_t        state_q, state_d;
  logic          ksel_q;
  logic [AW-1:0] widx_q;
  logic [AW-1:0] ridx_q;
  logic [AW-1:0] kval_m1;
  logic [AW-1:0] pi;
  logic [1:0]    tail_q;
  logic          wr_en;
  logic          gen_load;
  logic          gen_step;
  logic          mem [KMAX];

  assign kval_m1   = kval_of(ksel_q) - AW'(1);
  assign dbg_state = state_q;

  // state register
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // next state, buffer write strobe and address-generator controls
  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    gen_load = 1'b0;
    gen_step = 1'b0;
    in_ready = 1'b0;
    busy     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (din_valid) begin
          wr_en   = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (din_valid) begin
          wr_en = 1'b1;
          if (widx_q == kval_m1) begin
            gen_load = 1'b1;
            state_d  = ST_READ;
          end
        end
      end
      ST_READ: begin
        gen_step = 1'b1;
        if (ridx_q == kval_m1) state_d = ST_TAIL;
      end
      ST_TAIL: begin
        // The first TAIL cycle still presents the registered last bit, so
        // the state is held TAIL_LEN+1 cycles to give TAIL_LEN quiet cycles.
        if (tail_q == 2'(TAIL_LEN)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // block-size latch, write/read indices and tail counter
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      ksel_q <= 1'b0;
      widx_q <= '0;
      ridx_q <= '0;
      tail_q <= '0;
    end else begin
      if (state_q == ST_IDLE && din_valid) ksel_q <= K;
      if (wr_en) widx_q <= (state_d == ST_READ) ? '0 : widx_q + AW'(1);
      if (state_q == ST_READ) ridx_q <= (ridx_q == kval_m1) ? '0 : ridx_q + AW'(1);
      tail_q <= (state_q == ST_TAIL) ? tail_q + 2'd1 : 2'd0;
    end
  end

  // block buffer: one write port, contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[widx_q] <= din;
  end

  qpp_addr_gen u_addr_gen (
    .clk  (clk),
    .aclr (aclr),
    .ksel (ksel_q),
    .load (gen_load),
    .step (gen_step),
    .pi   (pi)
  );

  // registered output stage: natural and interleaved reads of the buffer
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      out_valid  <= 1'b0;
      data_ready <= 1'b0;
      ck         <= 1'b0;
      ck_int     <= 1'b0;
    end else begin
      out_valid  <= (state_q == ST_READ);
      data_ready <= (state_q == ST_READ) && (ridx_q == '0);
      ck         <= (state_q == ST_READ) ? mem[ridx_q] : 1'b0;
      ck_int     <= (state_q == ST_READ) ? mem[pi]     : 1'b0;
    end
  end

endmodule

// File: tb/tb_qpp_interleaver.sv
// Bench for qpp_interleaver: random blocks checked against a direct
// (f1*n + f2*n^2) mod K reference permutation.
module tb_qpp_interleaver;
  import turbo_pkg::*;

  logic   clk = 1'b0;
  logic   aclr, K, din, din_valid;
  logic   in_ready, data_ready, ck, ck_int, out_valid, busy;
  state_t dbg_state;

  int checks   = 0;
  int failures = 0;

  logic       blk[$];
  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];
  int         dr_cnt, dr_idx, lat, tail_len;
  bit         ir_after_last, tail_quiet, cap_timeout;

  qpp_interleaver dut (
    .clk        (clk),
    .aclr       (aclr),
    .K          (K),
    .din        (din),
    .din_valid  (din_valid),
    .in_ready   (in_ready),
    .data_ready (data_ready),
    .ck         (ck),
    .ck_int     (ck_int),
    .out_valid  (out_valid),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // reference permutation straight from the QPP definition
  function automatic int pi_ref(input int kk, input int n);
    longint f1, f2, nn;
    f1 = (kk == K_SMALL) ? 17 : 263;
    f2 = (kk == K_SMALL) ? 66 : 480;
    nn = longint'(n);
    return int'((f1 * nn + f2 * nn * nn) % longint'(kk));
  endfunction

  task automatic build_exp(input int kk);
    exp_q.delete();
    for (int n = 0; n < kk; n++) exp_q.push_back({blk[n], blk[pi_ref(kk, n)]});
  endtask

  function automatic int stream_errors(output int first);
    int bad;
    bad   = 0;
    first = -1;
    for (int n = 0; n < exp_q.size(); n++)
      if (n >= got_q.size() || got_q[n] !== exp_q[n]) begin
        bad++;
        if (first < 0) first = n;
      end
    if (got_q.size() > exp_q.size()) bad++;
    return bad;
  endfunction

  task automatic fill_random(input int n);
    blk.delete();
    for (int i = 0; i < n; i++) blk.push_back(1'($urandom));
  endtask

  // driver: push blk into the DUT, optional gaps, optional K flip after half
  task automatic load_block(input logic ksel, input int gap_pct, input bit k_flip);
    int n, i, guard;
    n = blk.size();
    i = 0;
    guard = 0;
    while (i < n && guard < 4 * n + 100) begin
      @(negedge clk);
      guard++;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        din_valid = 1'b0;
        din       = 1'($urandom);
      end else begin
        din_valid = 1'b1;
        din       = blk[i];
        i++;
      end
      K = (k_flip && i > n / 2) ? ~ksel : ksel;
    end
  endtask

  // monitor: collect one output block plus its tail, bounded by a cycle budget
  task automatic capture_block(input bit extra);
    int cyc;
    bit seen;
    got_q.delete();
    dr_cnt = 0; dr_idx = -1; lat = -1; tail_len = 0;
    tail_quiet = 1'b1; cap_timeout = 1'b1; ir_after_last = 1'b1;
    cyc = 0; seen = 1'b0;
    while (cyc < KMAX + 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) ir_after_last = in_ready;
      if (data_ready) begin dr_cnt++; dr_idx = got_q.size(); end
      if (out_valid) begin
        if (!seen) lat = cyc;
        seen = 1'b1;
        got_q.push_back({ck, ck_int});
      end else if (seen && busy) begin
        tail_len++;
        if (ck || ck_int) tail_quiet = 1'b0;
      end else if (seen && !busy) begin
        cap_timeout = 1'b0;
        din_valid = 1'b0;
        break;
      end
      if (extra && busy) begin
        din_valid = (tail_len > 0) ? 1'b1 : 1'($urandom_range(1));
        din       = 1'($urandom);
      end else begin
        din_valid = 1'b0;
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_ctrl: in_ready=%b busy=%b state=%0d, required 1 0 0", in_ready, busy, dbg_state);
    end
    checks++;
    if ({out_valid, data_ready, ck, ck_int} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_out: {out_valid,data_ready,ck,ck_int}=%b, required 0000", {out_valid, data_ready, ck, ck_int});
    end
    aclr = 1'b0;
  endtask

  task automatic test_alternating();
    int bad, first;
    logic v1, v2;
    blk.delete();
    for (int i = 0; i < K_SMALL; i++) blk.push_back(1'(i % 2));
    load_block(1'b0, 0, 1'b0);
    capture_block(1'b0);
    build_exp(K_SMALL);
    bad = stream_errors(first);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL t1_stream: %0d errors first at %0d, got_len=%0d required_len=%0d", bad, first, got_q.size(), K_SMALL);
    end
    v1 = (got_q.size() > 2) ? got_q[1][0] : 1'bx;
    v2 = (got_q.size() > 2) ? got_q[2][0] : 1'bx;
    checks++;
    if (v1 !== 1'b1 || v2 !== 1'b0) begin
      failures++;
      $display("FAIL t1_ck_int_1_2: got %b %b, required 1 0", v1, v2);
    end
    checks++;
    if (got_q.size() != K_SMALL) begin
      failures++;
      $display("FAIL t1_valid_len: got %0d, required %0d", got_q.size(), K_SMALL);
    end
    checks++;
    if (dr_cnt != 1 || dr_idx != 0) begin
      failures++;
      $display("FAIL t1_data_ready: pulses=%0d at %0d, required 1 at 0", dr_cnt, dr_idx);
    end
    checks++;
    if (lat != 2 || ir_after_last !== 1'b0) begin
      failures++;
      $display("FAIL t1_latency: first valid cycle %0d in_ready=%b, required 2 and 0", lat, ir_after_last);
    end
    checks++;
    if (tail_len != TAIL_LEN || !tail_quiet || cap_timeout) begin
      failures++;
      $display("FAIL t1_tail: len=%0d quiet=%b timeout=%b, required %0d 1 0", tail_len, tail_quiet, cap_timeout, TAIL_LEN);
    end
  endtask

  task automatic test_single_one();
    int int_ones, int_pos, ck_ones, ck_pos;
    blk.delete();
    for (int i = 0; i < K_LARGE; i++) blk.push_back(1'(i == 743));
    load_block(1'b1, 0, 1'b0);
    capture_block(1'b0);
    int_ones = 0; int_pos = -1; ck_ones = 0; ck_pos = -1;
    foreach (got_q[n]) begin
      if (got_q[n][0]) begin int_ones++; int_pos = n; end
      if (got_q[n][1]) begin ck_ones++; ck_pos = n; end
    end
    checks++;
    if (int_ones != 1 || int_pos != 1) begin
      failures++;
      $display("FAIL t2_ck_int: %0d ones last at %0d, required 1 at 1", int_ones, int_pos);
    end
    checks++;
    if (ck_ones != 1 || ck_pos != 743) begin
      failures++;
      $display("FAIL t2_ck: %0d ones last at %0d, required 1 at 743", ck_ones, ck_pos);
    end
  endtask

  task automatic test_random();
    int bad, first;
    fill_random(K_LARGE);
    load_block(1'b1, 0, 1'b0);
    capture_block(1'b0);
    build_exp(K_LARGE);
    bad = stream_errors(first);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL t3_stream: %0d errors first at %0d, got_len=%0d required_len=%0d", bad, first, got_q.size(), K_LARGE);
    end
    checks++;
    if (dr_cnt != 1 || dr_idx != 0 || tail_len != TAIL_LEN) begin
      failures++;
      $display("FAIL t3_framing: pulses=%0d at %0d tail=%0d, required 1 at 0 tail %0d", dr_cnt, dr_idx, tail_len, TAIL_LEN);
    end
  endtask

  task automatic test_back_to_back_gaps();
    int bad, first;
    logic [1:0] ref_q[$];
    fill_random(K_SMALL);
    load_block(1'b0, 0, 1'b0);
    capture_block(1'b0);
    ref_q = got_q;
    load_block(1'b0, 50, 1'b0);
    capture_block(1'b1);
    build_exp(K_SMALL);
    bad = stream_errors(first);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL t4_stream: %0d errors first at %0d, got_len=%0d required_len=%0d", bad, first, got_q.size(), K_SMALL);
    end
    checks++;
    if (got_q != ref_q) begin
      failures++;
      $display("FAIL t4_vs_gapfree: gapped run len=%0d differs from gap-free len=%0d, required identical", got_q.size(), ref_q.size());
    end
    checks++;
    if (tail_len != TAIL_LEN || !tail_quiet || cap_timeout) begin
      failures++;
      $display("FAIL t4_busy_tail: len=%0d quiet=%b timeout=%b, required %0d 1 0", tail_len, tail_quiet, cap_timeout, TAIL_LEN);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL t4_extra_ignored: state=%0d busy=%b in_ready=%b, required IDLE 0 1", dbg_state, busy, in_ready);
    end
  endtask

  task automatic test_abort();
    int bad, first, stray;
    fill_random(500);
    load_block(1'b1, 0, 1'b0);
    @(negedge clk);
    din_valid = 1'b0;
    checks++;
    if (dbg_state !== ST_LOAD || busy !== 1'b1) begin
      failures++;
      $display("FAIL t5_mid_load: state=%0d busy=%b, required LOAD 1", dbg_state, busy);
    end
    #2 aclr = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL t5_load_abort: busy=%b in_ready=%b state=%0d, required 0 1 IDLE", busy, in_ready, dbg_state);
    end
    @(negedge clk);
    aclr = 1'b0;
    fill_random(K_SMALL);
    load_block(1'b0, 0, 1'b0);
    capture_block(1'b0);
    build_exp(K_SMALL);
    bad = stream_errors(first);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL t5_after_abort: %0d errors first at %0d, got_len=%0d required_len=%0d", bad, first, got_q.size(), K_SMALL);
    end
    // abort in the middle of READ: out_valid must fall without a clock edge
    fill_random(K_SMALL);
    load_block(1'b0, 0, 1'b0);
    @(negedge clk);
    din_valid = 1'b0;
    repeat (100) @(negedge clk);
    #2 aclr = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || data_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL t5_read_abort: out_valid=%b data_ready=%b busy=%b, required 0 0 0", out_valid, data_ready, busy);
    end
    @(negedge clk);
    aclr = 1'b0;
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid || data_ready || busy) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL t5_no_resume: %0d active cycles after abort, required 0", stray);
    end
  endtask

  task automatic test_k_toggle();
    int bad, first;
    fill_random(K_LARGE);
    load_block(1'b1, 0, 1'b1);
    capture_block(1'b0);
    build_exp(K_LARGE);
    bad = stream_errors(first);
    checks++;
    if (got_q.size() != K_LARGE) begin
      failures++;
      $display("FAIL t6_len: out_valid cycles %0d, required %0d", got_q.size(), K_LARGE);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL t6_stream: %0d errors first at %0d", bad, first);
    end
  endtask

  initial begin
    aclr      = 1'b1;
    K         = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
    test_reset();
    test_alternating();
    test_single_one();
    test_random();
    test_back_to_back_gaps();
    test_abort();
    test_k_toggle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
